// File: rtl/pll_dyn_cfg_master.sv
// Serial configuration master for the PLL_B dynamic-config port with PLL reset and lock supervision.
// Latency: CFG_WIDTH*2*SCLK_DIV shift + 2*SCLK_DIV latch + RST_CYCLES reset + up to LOCK_TIMEOUT lock wait.
// Backpressure: START is only accepted while idle (BUSY=0, DONE=0); requests at other times are dropped.
`timescale 1ns/1ps
module pll_dyn_cfg_master #(
    parameter int CFG_WIDTH    = 24,
    parameter int SCLK_DIV     = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic [CFG_WIDTH-1:0] CFG_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 TIMEOUT,
    output logic [CFG_WIDTH-1:0] RDBACK,
    output logic                 PLL_SCLK,
    output logic                 PLL_SDI,
    output logic                 PLL_LATCH,
    output logic                 PLL_RESET_N,
    input  logic                 PLL_SDO,
    input  logic                 PLL_LOCK
);
    localparam int BIT_PERIOD = 2 * SCLK_DIV;
    localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES)
                           ? ((LOCK_TIMEOUT > BIT_PERIOD) ? LOCK_TIMEOUT : BIT_PERIOD)
                           : ((RST_CYCLES > BIT_PERIOD) ? RST_CYCLES : BIT_PERIOD);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam int BIT_W = $clog2(CFG_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_LATCH, S_PRST, S_WAIT_LOCK, S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CFG_WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [CFG_WIDTH-1:0] rdback_q, rdback_d;
    logic                 sdi_q, sdi_d;
    logic                 timeout_q, timeout_d;
    logic                 lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
    logic                 sclk_q, sclk_d, latch_q, latch_d, prst_n_q, prst_n_d;
    logic                 busy_q, busy_d, done_q, done_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            rdback_q    <= '0;
            sdi_q       <= 1'b0;
            timeout_q   <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
            prst_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rdback_q    <= rdback_d;
            sdi_q       <= sdi_d;
            timeout_q   <= timeout_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
            prst_n_q    <= prst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rdback_d    = rdback_q;
        sdi_d       = sdi_q;
        timeout_d   = timeout_q;
        lock_meta_d = PLL_LOCK;
        lock_s_d    = lock_meta_q;
        shifted     = shreg_q << 1;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_SHIFT;
                    cnt_d     = '0;
                    bit_d     = '0;
                    shreg_d   = CFG_DATA;
                    sdi_d     = CFG_DATA[CFG_WIDTH-1];
                    rdback_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            S_SHIFT: begin
                // SDO is sampled in the first high-phase cycle of each bit
                if (cnt_q == CNT_W'(SCLK_DIV))
                    rdback_d = (rdback_q << 1) | CFG_WIDTH'(PLL_SDO);
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(CFG_WIDTH - 1)) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shifted;
                        sdi_d   = shifted[CFG_WIDTH-1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PRST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // lock wins over timeout when both happen on the final count
                if (lock_s_q) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so every PLL-facing signal is a clean flop output.
    always_comb begin
        sclk_d   = (state_d == S_SHIFT) && (cnt_d >= CNT_W'(SCLK_DIV));
        latch_d  = (state_d == S_LATCH);
        prst_n_d = (state_d != S_PRST);
        busy_d   = (state_d == S_SHIFT) || (state_d == S_LATCH) ||
                   (state_d == S_PRST)  || (state_d == S_WAIT_LOCK);
        done_d   = (state_d == S_FINISH);
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT     = timeout_q;
    assign RDBACK      = rdback_q;
    assign PLL_SCLK    = sclk_q;
    assign PLL_SDI     = sdi_q;
    assign PLL_LATCH   = latch_q;
    assign PLL_RESET_N = prst_n_q;
endmodule

// File: tb/tb_pll_dyn_cfg_master.sv
// Bench for pll_dyn_cfg_master: behavioural PLL (loopback shift register, lock driver) plus
// per-scenario tasks comparing pin traces and readback against expectations derived from data.
`timescale 1ns/1ps
module tb_pll_dyn_cfg_master;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int RSTC = 16;
    localparam int LT   = 100;
    localparam int BITP = 2 * D;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] CFG_DATA = '0;
    logic         BUSY, DONE, TIMEOUT;
    logic [W-1:0] RDBACK;
    logic         PLL_SCLK, PLL_SDI, PLL_LATCH, PLL_RESET_N, PLL_SDO;
    logic         PLL_LOCK = 1'b0;
    int           checks = 0;
    int           errors = 0;

    pll_dyn_cfg_master #(.CFG_WIDTH(W), .SCLK_DIV(D), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CFG_DATA(CFG_DATA),
        .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .RDBACK(RDBACK),
        .PLL_SCLK(PLL_SCLK), .PLL_SDI(PLL_SDI), .PLL_LATCH(PLL_LATCH),
        .PLL_RESET_N(PLL_RESET_N), .PLL_SDO(PLL_SDO), .PLL_LOCK(PLL_LOCK)
    );

    always #5 CLK = ~CLK;

    // Behavioural PLL and pin recorder; records restart whenever a START is accepted.
    logic [W-1:0] model_q = '0;
    logic [W-1:0] mon_pre = '0;
    logic [W-1:0] model_at_latch = '0;
    bit           sdo_tie = 1'b0;
    logic         sclk_prev = 1'b0, rn_prev = 1'b1, cap_sdi = 1'b0;
    logic         sdi_tr[$];
    logic         sclk_tr[$];
    int cyc = 0, latch_cyc = 0, rstlo_cyc = 0, busy_cyc = 0, done_cnt = 0;
    int done_busy = 0, rise_cyc = 0, done_cyc = 0, latch_sdi_bad = 0;

    assign PLL_SDO = sdo_tie ? 1'b1 : model_q[W-1];

    always @(negedge CLK) begin
        cyc++;
        if (RESET_N && START && !BUSY && !DONE) begin
            sdi_tr.delete(); sclk_tr.delete();
            latch_cyc = 0; rstlo_cyc = 0; busy_cyc = 0; done_cnt = 0;
            done_busy = 0; rise_cyc = 0; done_cyc = 0; latch_sdi_bad = 0;
            model_q = mon_pre; sclk_prev = PLL_SCLK; rn_prev = PLL_RESET_N;
        end else begin
            if (PLL_SCLK && !sclk_prev) cap_sdi = PLL_SDI;
            if (!PLL_SCLK && sclk_prev) model_q = {model_q[W-2:0], cap_sdi};
            sclk_prev = PLL_SCLK;
            if (BUSY && latch_cyc == 0 && !PLL_LATCH) begin
                sdi_tr.push_back(PLL_SDI);
                sclk_tr.push_back(PLL_SCLK);
            end
            if (PLL_LATCH) begin
                if (latch_cyc == 0) model_at_latch = model_q;
                latch_cyc++;
                if (sdi_tr.size() > 0 && PLL_SDI !== sdi_tr[$]) latch_sdi_bad++;
            end
            if (!PLL_RESET_N) rstlo_cyc++;
            if (PLL_RESET_N && !rn_prev) rise_cyc = cyc;
            rn_prev = PLL_RESET_N;
            if (BUSY) busy_cyc++;
            if (DONE) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
                if (BUSY) done_busy++;
            end
        end
    end

    // Expected serial waveform: each bit MSB first, held 2*D cycles, SCLK low D then high D.
    function automatic int trace_errs(input logic [W-1:0] data);
        int bad = 0;
        if (sdi_tr.size() != W * BITP || sclk_tr.size() != W * BITP) return -1;
        for (int b = 0; b < W; b++)
            for (int c = 0; c < BITP; c++) begin
                if (sdi_tr[b*BITP+c] !== data[W-1-b]) bad++;
                if (sclk_tr[b*BITP+c] !== (c >= D)) bad++;
            end
        return bad;
    endfunction

    // Lock pin rises dly cycles after reset release; logic sees it 2 cycles later, decides 1 cycle later.
    function automatic int exp_lat(input int dly);
        return (dly >= 0 && dly + 2 < LT) ? dly + 3 : LT;
    endfunction

    function automatic logic exp_to(input int dly);
        return !(dly >= 0 && dly + 2 < LT);
    endfunction

    task automatic do_txn(input logic [W-1:0] data, input logic [W-1:0] pre, input bit tie,
                          input int dly, input bit mid_start, input bit pre_started,
                          input bit stop_at_done);
        int n;
        mon_pre = pre; sdo_tie = tie; PLL_LOCK = 1'b0;
        if (!pre_started) begin
            CFG_DATA = data; START = 1'b1;
            @(posedge CLK); #1;
            START = 1'b0; CFG_DATA = W'($urandom);
        end
        if (mid_start) begin
            repeat (9) @(posedge CLK);
            #1; START = 1'b1; CFG_DATA = ~data;
            @(posedge CLK); #1; START = 1'b0;
        end
        n = 0; while (PLL_RESET_N !== 1'b0 && n < 1000) begin @(posedge CLK); #1; n++; end
        n = 0; while (PLL_RESET_N !== 1'b1 && n < 1000) begin @(posedge CLK); #1; n++; end
        if (dly >= 0) begin
            repeat (dly) @(posedge CLK);
            #1; PLL_LOCK = 1'b1;
        end
        n = 0; while (done_cnt == 0 && DONE !== 1'b1 && n < 1000) begin @(posedge CLK); #1; n++; end
        if (!stop_at_done) begin
            repeat (4) @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, TIMEOUT, PLL_SCLK, PLL_SDI, PLL_LATCH, PLL_RESET_N} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000001",
                     {BUSY, DONE, TIMEOUT, PLL_SCLK, PLL_SDI, PLL_LATCH, PLL_RESET_N});
        end
        checks++;
        if (RDBACK !== '0) begin errors++; $display("FAIL reset_rdback: got %h expected 00", RDBACK); end
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_shift_pattern;
        int e;
        do_txn(8'hA5, 8'h00, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        e = trace_errs(8'hA5);
        checks++; if (e !== 0) begin errors++; $display("FAIL shift_trace: got %0d bad samples expected 0", e); end
        checks++; if (latch_cyc !== BITP) begin errors++; $display("FAIL latch_len: got %0d expected %0d", latch_cyc, BITP); end
        checks++; if (rstlo_cyc !== RSTC) begin errors++; $display("FAIL prst_len: got %0d expected %0d", rstlo_cyc, RSTC); end
        checks++; if (latch_sdi_bad !== 0) begin errors++; $display("FAIL latch_sdi_hold: got %0d bad expected 0", latch_sdi_bad); end
        checks++; if (RDBACK !== 8'hFF) begin errors++; $display("FAIL rdback_tied: got %h expected ff", RDBACK); end
    endtask

    task automatic test_loopback;
        do_txn(8'hC3, 8'h3C, 1'b0, 5, 1'b0, 1'b0, 1'b0);
        checks++; if (RDBACK !== 8'h3C) begin errors++; $display("FAIL loop_rdback: got %h expected 3c", RDBACK); end
        checks++; if (model_at_latch !== 8'hC3) begin errors++; $display("FAIL loop_pllreg: got %h expected c3", model_at_latch); end
    endtask

    task automatic test_lock_latency;
        do_txn(W'($urandom), W'($urandom), 1'b0, 5, 1'b0, 1'b0, 1'b0);
        checks++; if (done_cyc - rise_cyc !== 8) begin errors++; $display("FAIL lock_latency: got %0d expected 8", done_cyc - rise_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL lock_done_pulse: got %0d expected 1", done_cnt); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL lock_timeout_flag: got %b expected 0", TIMEOUT); end
        checks++; if (done_busy !== 0) begin errors++; $display("FAIL busy_on_done: got %0d expected 0", done_busy); end
        checks++;
        if (busy_cyc !== W*BITP + BITP + RSTC + 8) begin
            errors++; $display("FAIL busy_len: got %0d expected %0d", busy_cyc, W*BITP + BITP + RSTC + 8);
        end
    endtask

    task automatic test_timeout;
        logic [W-1:0] d;
        do_txn(W'($urandom), W'($urandom), 1'b0, -1, 1'b0, 1'b0, 1'b0);
        checks++; if (done_cyc - rise_cyc !== LT) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", done_cyc - rise_cyc, LT); end
        checks++; if (TIMEOUT !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL timeout_flag: got %b/%0d expected 1/1", TIMEOUT, done_cnt); end
        d = W'($urandom);
        mon_pre = W'($urandom); PLL_LOCK = 1'b0; CFG_DATA = d; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        checks++; if (TIMEOUT !== 1'b0 || RDBACK !== '0) begin errors++; $display("FAIL timeout_clear: got %b/%h expected 0/00", TIMEOUT, RDBACK); end
        do_txn(d, mon_pre, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (TIMEOUT !== 1'b0 || done_cyc - rise_cyc !== 3) begin errors++; $display("FAIL after_timeout: got %b/%0d expected 0/3", TIMEOUT, done_cyc - rise_cyc); end
    endtask

    task automatic test_lock_boundary;
        for (int dly = LT - 3; dly <= LT - 2; dly++) begin
            do_txn(W'($urandom), W'($urandom), 1'b0, dly, 1'b0, 1'b0, 1'b0);
            checks++;
            if (TIMEOUT !== exp_to(dly) || done_cyc - rise_cyc !== exp_lat(dly)) begin
                errors++;
                $display("FAIL lock_boundary dly=%0d: got %b/%0d expected %b/%0d", dly, TIMEOUT,
                         done_cyc - rise_cyc, exp_to(dly), exp_lat(dly));
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] d;
        int e;
        d = W'($urandom);
        do_txn(d, W'($urandom), 1'b0, 2, 1'b1, 1'b0, 1'b0);
        e = trace_errs(d);
        checks++; if (e !== 0 || model_at_latch !== d) begin errors++; $display("FAIL ignore_start_word: got %0d bad/%h expected 0/%h", e, model_at_latch, d); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_start_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] d, p;
        d = W'($urandom); p = W'($urandom);
        mon_pre = p; sdo_tie = 1'b0; PLL_LOCK = 1'b0; CFG_DATA = d; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        checks++; if (PLL_SCLK !== 1'b1) begin errors++; $display("FAIL abort_precond_sclk: got %b expected 1", PLL_SCLK); end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, TIMEOUT, PLL_SCLK, PLL_LATCH, PLL_RESET_N} !== 6'b000001 || RDBACK !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %b/%h expected 000001/00",
                     {BUSY, DONE, TIMEOUT, PLL_SCLK, PLL_LATCH, PLL_RESET_N}, RDBACK);
        end
        repeat (5) @(posedge CLK);
        #1; RESET_N = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        checks++;
        if (latch_cyc !== 0 || done_cnt !== 0 || rstlo_cyc !== 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_latch: got latch=%0d done=%0d prst=%0d busy=%b expected 0/0/0/0",
                     latch_cyc, done_cnt, rstlo_cyc, BUSY);
        end
        do_txn(d, p, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        checks++;
        if (RDBACK !== p || model_at_latch !== d || done_cnt !== 1) begin
            errors++; $display("FAIL abort_recover: got %h/%h/%0d expected %h/%h/1", RDBACK, model_at_latch, done_cnt, p, d);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] d, p;
        int e;
        do_txn(W'($urandom), W'($urandom), 1'b0, 1, 1'b0, 1'b0, 1'b1);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", DONE); end
        d = W'($urandom); p = W'($urandom);
        mon_pre = p; PLL_LOCK = 1'b0; CFG_DATA = d; START = 1'b1;
        @(posedge CLK); #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: got busy %b expected 0", BUSY); end
        @(posedge CLK); #1; START = 1'b0; CFG_DATA = ~d;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", BUSY); end
        do_txn(d, p, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        e = trace_errs(d);
        checks++;
        if (e !== 0 || RDBACK !== p || done_cyc - rise_cyc !== 6) begin
            errors++; $display("FAIL b2b_second: got %0d bad/%h/%0d expected 0/%h/6", e, RDBACK, done_cyc - rise_cyc, p);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] d, p;
        int dly, e;
        bit tie;
        for (int i = 0; i < 5; i++) begin
            d = W'($urandom); p = W'($urandom); tie = 1'($urandom);
            dly = $urandom_range(0, LT + 5);
            do_txn(d, p, tie, dly, 1'b0, 1'b0, 1'b0);
            e = trace_errs(d);
            checks++;
            if (e !== 0 || RDBACK !== (tie ? {W{1'b1}} : p) || model_at_latch !== d) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %0d bad/%h/%h expected 0/%h/%h", i, e, RDBACK,
                         model_at_latch, tie ? {W{1'b1}} : p, d);
            end
            checks++;
            if (TIMEOUT !== exp_to(dly) || done_cyc - rise_cyc !== exp_lat(dly) || done_cnt !== 1 ||
                busy_cyc !== W*BITP + BITP + RSTC + exp_lat(dly)) begin
                errors++;
                $display("FAIL rand_timing[%0d] dly=%0d: got to=%b lat=%0d done=%0d busy=%0d expected %b/%0d/1/%0d",
                         i, dly, TIMEOUT, done_cyc - rise_cyc, done_cnt, busy_cyc, exp_to(dly), exp_lat(dly),
                         W*BITP + BITP + RSTC + exp_lat(dly));
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_pattern();
        test_loopback();
        test_lock_latency();
        test_timeout();
        test_lock_boundary();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
